// File: rtl/pipe_pkg.sv
// Shared types and state encoding for the elastic pipeline stage.
package pipe_pkg;

    typedef logic [1:0] occ_t;

    localparam occ_t ST_EMPTY = 2'd0;
    localparam occ_t ST_ONE   = 2'd1;
    localparam occ_t ST_TWO   = 2'd2;

endpackage

// File: rtl/pipe_data_reg.sv
// Load-enabled register with asynchronous active-low reset to zero.
module pipe_data_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Valid/ready pipeline stage register with optional 2-entry skid buffer,
// synchronous flush and control-bit bubbling.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int unsigned NUM_WORDS = 3,
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned CTRL_W    = 2,
    parameter int unsigned SKID      = 1
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_WORDS*WORD_W-1:0] in_words,
    input  logic [CTRL_W-1:0]           in_ctrl,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NUM_WORDS*WORD_W-1:0] out_words,
    output logic [CTRL_W-1:0]           out_ctrl,
    output logic [1:0]                  occupancy
);

    localparam int unsigned DATA_W  = NUM_WORDS * WORD_W;
    localparam int unsigned ENTRY_W = DATA_W + CTRL_W;

    occ_t               state_q, state_d;
    logic               in_fire, out_fire;
    logic               main_load, skid_load;
    logic [ENTRY_W-1:0] in_entry, main_d, main_q, skid_q;

    assign in_entry  = {in_ctrl, in_words};
    assign out_valid = (state_q != ST_EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d   = state_q;
        main_load = 1'b0;
        skid_load = 1'b0;
        main_d    = in_entry;
        // Flush wins over everything; data registers keep their contents.
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d   = ST_ONE;
                        main_load = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (in_fire) begin
                        state_d   = ST_TWO;
                        skid_load = 1'b1;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        state_d   = ST_ONE;
                        main_load = 1'b1;
                        main_d    = skid_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    pipe_data_reg #(
        .WIDTH (ENTRY_W)
    ) u_main (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (main_load),
        .d       (main_d),
        .q       (main_q)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic in_ready_q;

            pipe_data_reg #(
                .WIDTH (ENTRY_W)
            ) u_skid (
                .clock   (clock),
                .reset_n (reset_n),
                .load    (skid_load),
                .d       (in_entry),
                .q       (skid_q)
            );

            // Registered ready keeps out_ready off every combinational output path.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    in_ready_q <= 1'b1;
                end else begin
                    in_ready_q <= (state_d != ST_TWO);
                end
            end

            assign in_ready = in_ready_q;
        end else begin : g_no_skid
            assign skid_q   = '0;
            assign in_ready = ~out_valid | out_ready;
        end
    endgenerate

    assign out_words = main_q[DATA_W-1:0];
    assign out_ctrl  = out_valid ? main_q[ENTRY_W-1:DATA_W] : '0;
    assign occupancy = state_q;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: SKID=1 and SKID=0 instances checked against a queue model.
module tb_pipe_stage_elastic;

    localparam int NW = 3;
    localparam int WW = 32;
    localparam int CW = 2;
    localparam int DW = NW * WW;
    localparam int EW = DW + CW;
    localparam int GW = 1 + 1 + 2 + CW + DW;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] in_words = '0;
    logic [CW-1:0] in_ctrl = '0;

    logic          in_ready1, out_valid1, in_ready0, out_valid0;
    logic [DW-1:0] out_words1, out_words0;
    logic [CW-1:0] out_ctrl1, out_ctrl0;
    logic [1:0]    occ1, occ0;

    int total = 0;
    int bad = 0;

    // Reference model: each stage is a bounded FIFO of {ctrl, words}.
    logic [EW-1:0] m1[$];
    logic [EW-1:0] m0[$];
    logic          rdy1 = 1'b1;

    always #5 clock = ~clock;

    pipe_stage_elastic #(
        .NUM_WORDS (NW), .WORD_W (WW), .CTRL_W (CW), .SKID (1)
    ) dut1 (
        .clock (clock), .reset_n (reset_n), .flush (flush),
        .in_valid (in_valid), .in_ready (in_ready1), .in_words (in_words), .in_ctrl (in_ctrl),
        .out_valid (out_valid1), .out_ready (out_ready), .out_words (out_words1),
        .out_ctrl (out_ctrl1), .occupancy (occ1)
    );

    pipe_stage_elastic #(
        .NUM_WORDS (NW), .WORD_W (WW), .CTRL_W (CW), .SKID (0)
    ) dut0 (
        .clock (clock), .reset_n (reset_n), .flush (flush),
        .in_valid (in_valid), .in_ready (in_ready0), .in_words (in_words), .in_ctrl (in_ctrl),
        .out_valid (out_valid0), .out_ready (out_ready), .out_words (out_words0),
        .out_ctrl (out_ctrl0), .occupancy (occ0)
    );

    // Advance the model with the inputs now applied, then cross one rising edge.
    task automatic step();
        logic r0, f1i, f1o, f0i, f0o;
        r0  = (m0.size() == 0) || out_ready;
        f1i = in_valid && rdy1;
        f1o = (m1.size() != 0) && out_ready;
        f0i = in_valid && r0;
        f0o = (m0.size() != 0) && out_ready;
        if (flush) begin
            m1.delete();
            m0.delete();
        end else begin
            if (f1o) void'(m1.pop_front());
            if (f1i) m1.push_back({in_ctrl, in_words});
            if (f0o) void'(m0.pop_front());
            if (f0i) m0.push_back({in_ctrl, in_words});
        end
        rdy1 = (m1.size() < 2);
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();
    endtask

    function automatic logic [GW-1:0] got1();
        got1 = {in_ready1, out_valid1, occ1, out_ctrl1,
                (m1.size() != 0) ? out_words1 : {DW{1'b0}}};
    endfunction

    function automatic logic [GW-1:0] got0();
        got0 = {in_ready0, out_valid0, occ0, out_ctrl0,
                (m0.size() != 0) ? out_words0 : {DW{1'b0}}};
    endfunction

    function automatic logic [GW-1:0] exp1();
        logic [1:0]    n;
        logic [EW-1:0] head;
        n    = 2'(m1.size());
        head = (n != 0) ? m1[0] : '0;
        exp1 = {rdy1, n != 0, n, head};
    endfunction

    function automatic logic [GW-1:0] exp0();
        logic [1:0]    n;
        logic [EW-1:0] head;
        n    = 2'(m0.size());
        head = (n != 0) ? m0[0] : '0;
        exp0 = {(n == 0) || out_ready, n != 0, n, head};
    endfunction

    task automatic test_reset();
        in_valid = 1'b1;
        in_ctrl  = 2'b11;
        in_words = {32'd9, 32'd8, 32'd7};
        @(posedge clock);
        #1;
        total++;
        if ({out_valid1, out_ctrl1, occ1, out_words1} !== '0) begin
            bad++;
            $display("FAIL reset1 got v=%b c=%b o=%0d w=%h want all zero",
                     out_valid1, out_ctrl1, occ1, out_words1);
        end
        total++;
        if ({out_valid0, out_ctrl0, occ0, out_words0} !== '0) begin
            bad++;
            $display("FAIL reset0 got v=%b c=%b o=%0d w=%h want all zero",
                     out_valid0, out_ctrl0, occ0, out_words0);
        end
        in_valid = 1'b0;
        reset_n  = 1'b1;
        #1;
        total++;
        if (in_ready1 !== 1'b1 || in_ready0 !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready got %b%b want 11", in_ready1, in_ready0);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_fill();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 2'b11;
        in_words  = {32'd3, 32'd2, 32'd1};
        step();
        in_valid = 1'b0;
        total++;
        if (out_valid1 !== 1'b1 || out_ctrl1 !== 2'b11 || out_words1 !== {32'd3, 32'd2, 32'd1})
        begin
            bad++;
            $display("FAIL fill got v=%b c=%b w=%h want v=1 c=11 w=3,2,1",
                     out_valid1, out_ctrl1, out_words1);
        end
        total++;
        if (got0() !== exp0()) begin
            bad++;
            $display("FAIL fill0 got %h want %h", got0(), exp0());
        end
    endtask

    task automatic test_stream();
        drain();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_ctrl  = 2'(i);
            in_words = {32'(i), 32'(i), 32'h0A0 + 32'(i)};
            step();
            total++;
            if (out_valid1 !== 1'b1 || out_words1[31:0] !== 32'h0A0 + 32'(i)
                || out_valid0 !== 1'b1 || out_words0[31:0] !== 32'h0A0 + 32'(i)) begin
                bad++;
                $display("FAIL stream beat %0d got v=%b%b w=%h/%h want %h",
                         i, out_valid1, out_valid0, out_words1[31:0], out_words0[31:0],
                         32'h0A0 + i);
            end
        end
        in_valid = 1'b0;
        step();
        total++;
        if (got1() !== exp1() || got0() !== exp0()) begin
            bad++;
            $display("FAIL stream_end got %h/%h want %h/%h", got1(), got0(), exp1(), exp0());
        end
    endtask

    task automatic test_backpressure();
        drain();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 2'b01;
        in_words  = {64'd0, 32'h0B0};
        step();
        in_words  = {64'd0, 32'h0B1};
        step();
        in_valid = 1'b0;
        total++;
        if (occ1 !== 2'd2 || in_ready1 !== 1'b0 || out_words1[31:0] !== 32'h0B0) begin
            bad++;
            $display("FAIL bp_full got occ=%0d rdy=%b w=%h want occ=2 rdy=0 w=b0",
                     occ1, in_ready1, out_words1[31:0]);
        end
        total++;
        if (got0() !== exp0()) begin
            bad++;
            $display("FAIL bp_full0 got %h want %h", got0(), exp0());
        end
        out_ready = 1'b1;
        step();
        total++;
        if (occ1 !== 2'd1 || in_ready1 !== 1'b1 || out_words1[31:0] !== 32'h0B1) begin
            bad++;
            $display("FAIL bp_drain got occ=%0d rdy=%b w=%h want occ=1 rdy=1 w=b1",
                     occ1, in_ready1, out_words1[31:0]);
        end
        step();
        total++;
        if (got1() !== exp1() || occ1 !== 2'd0) begin
            bad++;
            $display("FAIL bp_empty got %h want %h", got1(), exp1());
        end
    endtask

    task automatic test_flush();
        drain();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 2'b11;
        in_words  = {64'd0, 32'h0C1};
        step();
        in_words  = {64'd0, 32'h0C2};
        step();
        in_words  = {64'd0, 32'h0C0};
        flush     = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        total++;
        if (out_valid1 !== 1'b0 || out_ctrl1 !== 2'b00 || occ1 !== 2'd0) begin
            bad++;
            $display("FAIL flush got v=%b c=%b occ=%0d want 0 0 0", out_valid1, out_ctrl1, occ1);
        end
        total++;
        if (got0() !== exp0()) begin
            bad++;
            $display("FAIL flush0 got %h want %h", got0(), exp0());
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (out_valid1 !== 1'b0 || out_valid0 !== 1'b0) begin
                bad++;
                $display("FAIL flush_leak cyc %0d got v=%b%b w=%h want no beat",
                         i, out_valid1, out_valid0, out_words1[31:0]);
            end
        end
    endtask

    task automatic test_simultaneous();
        drain();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 2'b10;
        in_words  = {64'd0, 32'h0D0};
        step();
        out_ready = 1'b1;
        in_words  = {64'd0, 32'h0D1};
        step();
        in_valid = 1'b0;
        total++;
        if (occ1 !== 2'd1 || out_words1[31:0] !== 32'h0D1 || occ0 !== 2'd1
            || out_words0[31:0] !== 32'h0D1) begin
            bad++;
            $display("FAIL simul got occ=%0d/%0d w=%h/%h want 1 d1",
                     occ1, occ0, out_words1[31:0], out_words0[31:0]);
        end
    endtask

    task automatic test_async_reset();
        drain();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 2'b11;
        in_words  = {64'd5, 32'h0E8};
        step();
        in_words  = {64'd6, 32'h0E9};
        step();
        in_valid = 1'b0;
        total++;
        if (occ1 !== 2'd2) begin
            bad++;
            $display("FAIL ar_pre got occ=%0d want 2", occ1);
        end
        #2;
        reset_n = 1'b0;
        m1.delete();
        m0.delete();
        rdy1 = 1'b1;
        #1;
        total++;
        if ({out_valid1, out_ctrl1, occ1, out_words1} !== '0
            || {out_valid0, out_ctrl0, occ0, out_words0} !== '0) begin
            bad++;
            $display("FAIL ar_zero got v=%b%b c=%b/%b occ=%0d/%0d want zero",
                     out_valid1, out_valid0, out_ctrl1, out_ctrl0, occ1, occ0);
        end
        #2;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_ctrl   = 2'b01;
        in_words  = {64'd7, 32'h0E0};
        step();
        in_valid = 1'b0;
        total++;
        if (out_words1 !== {64'd7, 32'h0E0} || out_ctrl1 !== 2'b01 || out_valid1 !== 1'b1
            || out_words0 !== {64'd7, 32'h0E0} || out_ctrl0 !== 2'b01) begin
            bad++;
            $display("FAIL ar_post got w=%h c=%b/%b want e0 c=01",
                     out_words1[31:0], out_ctrl1, out_ctrl0);
        end
    endtask

    task automatic test_random();
        drain();
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 20) == 0;
            in_ctrl   = 2'($urandom);
            in_words  = {$urandom, $urandom, $urandom};
            step();
            total++;
            if (got1() !== exp1()) begin
                bad++;
                $display("FAIL rand1 cyc %0d got %h want %h", i, got1(), exp1());
            end
            total++;
            if (got0() !== exp0()) begin
                bad++;
                $display("FAIL rand0 cyc %0d got %h want %h", i, got0(), exp0());
            end
        end
        flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_stream();
        test_backpressure();
        test_flush();
        test_simultaneous();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
